// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read one-write register file with x0 hardwired to zero and a post-reset clear sweep
module regfile_2r1w #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ra_enable,
  input  logic [AW-1:0]   ra_select,
  output logic [XLEN-1:0] ra_out,
  output logic            ra_valid,
  input  logic            rb_enable,
  input  logic [AW-1:0]   rb_select,
  output logic [XLEN-1:0] rb_out,
  output logic            rb_valid,
  input  logic            w_enable,
  input  logic [AW-1:0]   w_select,
  input  logic [XLEN-1:0] w_val,
  output logic            ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_idx, clr_idx_n;
  logic [XLEN-1:0] mem [NREGS];
  logic [XLEN-1:0] ra_d, rb_d;
  logic run, last, wr_ok;
  assign run   = state == RUN;
  assign last  = clr_idx == AW'(NREGS - 1);
  assign wr_ok = run && w_enable && w_select != '0;
  always_comb begin
    state_n   = (state == CLEAR && last) ? RUN : state;
    clr_idx_n = (state == CLEAR && !last) ? clr_idx + AW'(1) : clr_idx;
  end
  // x0 reads as zero; a same-edge write to the read index is forwarded only when BYPASS is set
  always_comb begin
    ra_d = (ra_select == '0) ? '0
         : (BYPASS != 0 && wr_ok && w_select == ra_select) ? w_val : mem[ra_select];
    rb_d = (rb_select == '0) ? '0
         : (BYPASS != 0 && wr_ok && w_select == rb_select) ? w_val : mem[rb_select];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_idx  <= AW'(1);
      ready    <= 1'b0;
      ra_valid <= 1'b0;
      rb_valid <= 1'b0;
      ra_out   <= '0;
      rb_out   <= '0;
    end else begin
      state    <= state_n;
      clr_idx  <= clr_idx_n;
      ready    <= state_n == RUN;
      ra_valid <= run && ra_enable;
      rb_valid <= run && rb_enable;
      if (run && ra_enable) ra_out <= ra_d;
      if (run && rb_enable) rb_out <= rb_d;
    end
  end
  // entry 0 is never written; the sweep covers 1..NREGS-1
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) mem[clr_idx] <= '0;
      else if (wr_ok) mem[w_select] <= w_val;
    end
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed scoreboard bench for default, no-bypass and 64x8 register files
module tb_regfile_2r1w;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic ra_enable, rb_enable, w_enable;
  logic [4:0] ra_select, rb_select, w_select;
  logic [31:0] w_val;
  logic [31:0] ra_out, rb_out, nb_ra_out, nb_rb_out;
  logic ra_valid, rb_valid, ready, nb_ra_valid, nb_rb_valid, nb_ready;
  logic c_ra_enable, c_rb_enable, c_w_enable;
  logic [2:0] c_ra_select, c_rb_select, c_w_select;
  logic [63:0] c_w_val, c_ra_out, c_rb_out;
  logic c_ra_valid, c_rb_valid, c_ready;
  int n = 0;
  int errs = 0;

  regfile_2r1w dut (
    .clk(clk), .rst_n(rst_n),
    .ra_enable(ra_enable), .ra_select(ra_select), .ra_out(ra_out), .ra_valid(ra_valid),
    .rb_enable(rb_enable), .rb_select(rb_select), .rb_out(rb_out), .rb_valid(rb_valid),
    .w_enable(w_enable), .w_select(w_select), .w_val(w_val), .ready(ready)
  );
  regfile_2r1w #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .ra_enable(ra_enable), .ra_select(ra_select), .ra_out(nb_ra_out), .ra_valid(nb_ra_valid),
    .rb_enable(rb_enable), .rb_select(rb_select), .rb_out(nb_rb_out), .rb_valid(nb_rb_valid),
    .w_enable(w_enable), .w_select(w_select), .w_val(w_val), .ready(nb_ready)
  );
  regfile_2r1w #(.XLEN(64), .NREGS(8)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .ra_enable(c_ra_enable), .ra_select(c_ra_select), .ra_out(c_ra_out), .ra_valid(c_ra_valid),
    .rb_enable(c_rb_enable), .rb_select(c_rb_select), .rb_out(c_rb_out), .rb_valid(c_rb_valid),
    .w_enable(c_w_enable), .w_select(c_w_select), .w_val(c_w_val), .ready(c_ready)
  );

  typedef struct {
    string tag;
    logic av;
    logic [31:0] a;
    logic bv;
    logic [31:0] b;
    logic [31:0] a_nb;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic ae, input logic [4:0] asel,
                      input logic be, input logic [4:0] bsel,
                      input logic we, input logic [4:0] wsel, input logic [31:0] wv,
                      input logic eav, input logic [31:0] ea, input logic ebv,
                      input logic [31:0] eb, input logic [31:0] ea_nb);
    exp_t e;
    @(negedge clk);
    ra_enable = ae; ra_select = asel; rb_enable = be; rb_select = bsel;
    w_enable = we; w_select = wsel; w_val = wv;
    q.push_back('{tag, eav, ea, ebv, eb, ea_nb});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, "_av"}, {63'd0, ra_valid}, {63'd0, e.av});
    chk({e.tag, "_a"}, {32'd0, ra_out}, {32'd0, e.a});
    chk({e.tag, "_bv"}, {63'd0, rb_valid}, {63'd0, e.bv});
    chk({e.tag, "_b"}, {32'd0, rb_out}, {32'd0, e.b});
    chk({e.tag, "_a_nb"}, {32'd0, nb_ra_out}, {32'd0, e.a_nb});
  endtask

  initial begin
    rst_n = 1'b0;
    {ra_enable, rb_enable, w_enable} = '0;
    {ra_select, rb_select, w_select} = '0;
    w_val = '0;
    {c_ra_enable, c_rb_enable, c_w_enable} = '0;
    {c_ra_select, c_rb_select, c_w_select} = '0;
    c_w_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_av", {63'd0, ra_valid}, 64'd0);
    chk("rst_a", {32'd0, ra_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sweep_ready_%0d", i), {63'd0, ready}, {63'd0, i == 31});
      chk($sformatf("sweep64_ready_%0d", i), {63'd0, c_ready}, {63'd0, i >= 7});
    end
    for (int i = 0; i < 32; i++)
      step($sformatf("zero_rd_%0d", i), 1, 5'(i), 1, 5'(31 - i), 0, 0, 0, 1, 0, 1, 0, 0);
    step("w5", 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step("rd5", 1, 5, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
    step("w0", 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    step("rd0", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("w7a", 0, 0, 0, 0, 1, 7, 32'h1, 0, 0, 0, 0, 0);
    step("byp7", 1, 7, 0, 0, 1, 7, 32'h12345678, 1, 32'h12345678, 0, 0, 32'h1);
    step("rd7", 1, 7, 1, 7, 0, 0, 0, 1, 32'h12345678, 1, 32'h12345678, 32'h12345678);
    step("w3", 0, 0, 0, 0, 1, 3, 32'hAA, 0, 32'h12345678, 0, 32'h12345678, 32'h12345678);
    step("rd3", 1, 3, 0, 0, 0, 0, 0, 1, 32'hAA, 0, 32'h12345678, 32'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    ra_enable = 1'b1; ra_select = 5'd3;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    chk("mid_rst_av", {63'd0, ra_valid}, 64'd0);
    chk("mid_rst_a", {32'd0, ra_out}, 64'd0);
    chk("mid_rst_b", {32'd0, rb_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rb_enable = 1'b1; rb_select = 5'd3;
    w_enable = 1'b1; w_select = 5'd3; w_val = 32'h55;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("clr_av_%0d", i), {63'd0, ra_valid}, 64'd0);
      chk($sformatf("clr_bv_%0d", i), {63'd0, rb_valid}, 64'd0);
      chk($sformatf("clr_ready_%0d", i), {63'd0, ready}, {63'd0, i == 31});
    end
    step("rd3_after", 1, 3, 1, 3, 0, 0, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    ra_enable = 1'b0; rb_enable = 1'b0;
    c_w_enable = 1'b1; c_w_select = 3'd7; c_w_val = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    c_w_enable = 1'b0;
    c_ra_enable = 1'b1; c_ra_select = 3'd7;
    c_rb_enable = 1'b1; c_rb_select = 3'd0;
    @(posedge clk);
    #1;
    chk("x64_av", {63'd0, c_ra_valid}, 64'd1);
    chk("x64_a", c_ra_out, 64'hFFFF_0000_FFFF_0000);
    chk("x64_b", c_rb_out, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
